// File: rtl/rf2p_mc_pkg.sv
// Shared configuration for the multi-channel two-port register file.
// RF2P_OUTREG_EN selects the extra read output register (read latency 2).
package rf2p_mc_pkg;

  typedef enum logic {RF_IDLE, RF_CLEAR} rf_state_e;

  typedef enum logic [1:0] {GEN_SIM, GEN_FPGA, GEN_SYN} gen_mode_e;

  localparam gen_mode_e gen_mode = GEN_SIM;

`ifdef RF2P_OUTREG_EN
  localparam int unsigned RF_RD_LAT = 2;
`else
  localparam int unsigned RF_RD_LAT = 1;
`endif

endpackage

// File: rtl/rf2p_mc_array.sv
// Single-channel DWD x 2**AWD storage: synchronous write, asynchronous read of
// the pre-write contents. Storage is intentionally not reset.
module rf2p_array
  import rf2p_mc_pkg::*;
#(
  parameter int unsigned DWD = 16,
  parameter int unsigned AWD = 5
) (
  input  logic           clk,
  input  logic           we,
  input  logic [AWD-1:0] waddr,
  input  logic [DWD-1:0] wdata,
  input  logic [AWD-1:0] raddr,
  output logic [DWD-1:0] rdata
);

  localparam int unsigned WORDS = 2 ** AWD;

  // For GEN_SYN the library flow substitutes the hard RF macro wrapper that
  // carries this module name and port list; SIM/FPGA use this array.
  logic [DWD-1:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rf2p_mc.sv
// NCH-lane two-port register file with shared addressing, per-lane write mask,
// per-lane write-to-read bypass and a clear sequencer. Macro: RF2P_OUTREG_EN.
module rf2p_mc
  import rf2p_mc_pkg::*;
#(
  parameter int unsigned NCH = 4,
  parameter int unsigned DWD = 16,
  parameter int unsigned AWD = 5
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_clr,
  output logic                     o_busy,
  input  logic                     i_read,
  input  logic [AWD-1:0]           i_raddr,
  output logic                     o_rvalid,
  output logic [NCH-1:0][DWD-1:0]  o_rdata,
  input  logic                     i_write,
  input  logic [AWD-1:0]           i_waddr,
  input  logic [NCH-1:0]           i_wmask,
  input  logic [NCH-1:0][DWD-1:0]  i_wdata
);

  rf_state_e                state;
  logic [AWD-1:0]           clr_cnt;
  logic                     busy;
  logic                     rd_ok;
  logic                     hit;
  logic [NCH-1:0]           arr_we;
  logic [AWD-1:0]           arr_waddr;
  logic [NCH-1:0][DWD-1:0]  arr_wdata;
  logic [NCH-1:0][DWD-1:0]  arr_rdata;
  logic [NCH-1:0][DWD-1:0]  rd_word;
  logic                     rvalid_q;
  logic [NCH-1:0][DWD-1:0]  rdata_q;

  assign busy  = (state == RF_CLEAR);
  assign rd_ok = i_read & ~busy;
  assign hit   = i_write & (i_waddr == i_raddr);

  // While clearing, the sequencer owns the write port and user writes are dropped.
  always_comb begin
    arr_waddr = busy ? clr_cnt : i_waddr;
    arr_we    = '0;
    arr_wdata = '0;
    rd_word   = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      arr_we[c]    = busy | (i_write & i_wmask[c]);
      arr_wdata[c] = busy ? '0 : i_wdata[c];
      rd_word[c]   = (hit & i_wmask[c]) ? i_wdata[c] : arr_rdata[c];
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    rf2p_array #(
      .DWD (DWD),
      .AWD (AWD)
    ) u_array (
      .clk   (i_clk),
      .we    (arr_we[c]),
      .waddr (arr_waddr),
      .wdata (arr_wdata[c]),
      .raddr (i_raddr),
      .rdata (arr_rdata[c])
    );
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= RF_IDLE;
      clr_cnt <= '0;
      o_busy  <= 1'b0;
    end else begin
      case (state)
        RF_IDLE: begin
          if (i_clr) begin
            state   <= RF_CLEAR;
            clr_cnt <= '0;
            o_busy  <= 1'b1;
          end
        end
        RF_CLEAR: begin
          if (i_clr) begin
            clr_cnt <= '0;
          end else if (clr_cnt == '1) begin
            state   <= RF_IDLE;
            clr_cnt <= '0;
            o_busy  <= 1'b0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: begin
          state   <= RF_IDLE;
          clr_cnt <= '0;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rd_ok;
      if (rd_ok) begin
        rdata_q <= rd_word;
      end
    end
  end

`ifdef RF2P_OUTREG_EN
  logic                     rvalid_q2;
  logic [NCH-1:0][DWD-1:0]  rdata_q2;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rvalid_q2 <= 1'b0;
      rdata_q2  <= '0;
    end else begin
      rvalid_q2 <= rvalid_q;
      if (rvalid_q) begin
        rdata_q2 <= rdata_q;
      end
    end
  end

  assign o_rvalid = rvalid_q2;
  assign o_rdata  = rdata_q2;
`else
  assign o_rvalid = rvalid_q;
  assign o_rdata  = rdata_q;
`endif

endmodule
